frv_lsu_pipelined: RTL and testbench
====================================

Name: frv_lsu_pipelined

Overview:
Parametrised successor to the single-outstanding LSU used by the memory stage. It issues load/store requests to the data bus and tracks up to DEPTH granted-but-unanswered transactions in an in-order tag queue. It formats load responses for writeback and supports pipeline flush of in-flight entries. It also implements a leakage fence that drains the queue and scrubs the response register with PRNG data.

Parameters:
XLEN, 32, data/address width (only 32 supported)
DEPTH, 4, max outstanding transactions (power of 2, >=2)
PW, $clog2(DEPTH), queue pointer width (derived, do not override)

Ports:
g_clk  in  1  global clock
g_resetn  in  1  synchronous reset, active-low
flush  in  1  kill all in-flight entries and any ungranted request
req_valid  in  1  request present
req_busy  out  1  request cannot be consumed this cycle
req_load  in  1  load
req_store  in  1  store
req_size  in  2  00 byte, 01 half, 10 word
req_signed  in  1  sign-extend load data
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data (LSB-aligned)
req_rd  in  5  destination register
req_aerr  out  1  misaligned request, combinational
hold_req  in  1  suppress new bus requests
dmem_req  out  1  bus request
dmem_wen  out  1  write enable
dmem_strb  out  4  byte strobe
dmem_wdata  out  XLEN  lane-shifted write data
dmem_addr  out  XLEN  word-aligned address
dmem_gnt  in  1  request accepted
dmem_recv  in  1  response valid (in order)
dmem_rdata  in  XLEN  response data
dmem_error  in  1  bus error on response
rsp_valid  out  1  registered load/error result
rsp_rd  out  5  result destination
rsp_data  out  XLEN  formatted load data
rsp_error  out  1  bus error for this entry
leak_fence  in  1  fence request pulse
leak_prng  in  XLEN  scrub value
fence_done  out  1  one-cycle fence completion pulse
spurious  out  1  sticky: dmem_recv with empty queue

Behaviour:
- Reset: count, ptrs, kill bits = 0; rsp_valid, rsp_error, rsp_rd, rsp_data, fence_done, spurious = 0; fence_pending = 0.
- Misalignment: half && addr[0], or word && addr[1:0]!=0.
  - req_aerr = req_valid && misaligned.
  - A misaligned request never raises dmem_req, consumes no slot and is consumed in its cycle (req_busy=0).
- Issue:
  - issue_ok = !hold_req && count<DEPTH && !fence_pending && !flush.
  - dmem_req = req_valid && !misaligned && issue_ok.
  - req_busy = req_valid && !misaligned && !(dmem_req && dmem_gnt).
  - The requester holds inputs stable while busy.
- Bus encoding: addr/wdata/strb are combinational from req_*. Strobe is 0001/0011/1111 << addr[1:0]. wdata is replicated into lanes.
- Push: on dmem_req && dmem_gnt, write entry {rd, load, size, signed, addr[1:0], kill=0} at wptr.
- Pop: on dmem_recv with count>0, read head and advance rptr. Push and pop in the same cycle leave count unchanged.
- Full and empty:
  - With count==DEPTH, dmem_req=0 even if a pop occurs that cycle (conservative).
  - dmem_recv with count==0 is ignored and sets spurious until reset.
- Response, registered with 1 cycle latency after dmem_recv:
  - rsp_valid = !kill && (load || dmem_error).
  - rsp_error = dmem_error.
  - rsp_data = dmem_rdata >> 8*offset, then zero/sign-extended per size. Stores return data 0.
  - rsp_valid is a single-cycle pulse with no back-pressure.
- Flush: sets kill on every valid entry. The request granted in the flush cycle cannot occur (issue_ok=0). Killed entries still pop on response but produce no rsp_valid.
- Fence:
  - A leak_fence pulse sets fence_pending and blocks issue.
  - When fence_pending && count==0 && !dmem_recv: next cycle fence_done=1, rsp_data<=leak_prng, rsp_valid=0, fence_pending cleared.
  - Fence arriving with an empty queue completes next cycle.
  - Fence while pending is absorbed.
- Reset mid-operation discards all entries; responses arriving afterwards count as spurious.

Decomposition:
- Shared package holds:
  - LSU_BYTE/HALF/WORD size encodings.
  - A tag-entry struct {rd, load, size, signed, offset, kill}.
  - A load-format function (shift + extend).
- One sub-module: frv_lsu_tagq, a DEPTH-entry circular queue with push/pop/count/full/empty and broadcast kill.

Test Plan:
- Aligned LW x5 @0x104, gnt same cycle, recv rdata=0xDEADBEEF 2 cycles later -> rsp_valid 1 cycle, rsp_rd=5, rsp_data=0xDEADBEEF.
- LB signed @0x203, rdata=0x80112233 -> strb=1000, rsp_data=0xFFFFFF80; LHU @0x202 same data -> 0x00008011.
- Issue 4 loads without recv (DEPTH=4) -> 5th request req_busy=1, dmem_req=0. One recv -> 5th issues the following cycle; responses return in issue order.
- LW @0x101 -> req_aerr=1, dmem_req=0, req_busy=0, count unchanged.
- 2 loads outstanding, flush -> both recvs pop with rsp_valid=0. A new load after flush responds normally.
- 3 outstanding, leak_fence, leak_prng=0xA5A5A5A5 -> no issue until 3 recvs. fence_done pulses the cycle after the last pop and rsp_data=0xA5A5A5A5. A dmem_recv with empty queue sets spurious=1.

Source files
------------

// File: rtl/frv_lsu_pkg.sv
// Shared types and helpers for the pipelined load/store unit.
package frv_lsu_pkg;

  // Access size encodings carried on req_size.
  localparam logic [1:0] LSU_BYTE = 2'b00;
  localparam logic [1:0] LSU_HALF = 2'b01;
  localparam logic [1:0] LSU_WORD = 2'b10;

  // One outstanding transaction, as remembered between grant and response.
  typedef struct packed {
    logic [4:0] rd;
    logic       load;
    logic [1:0] size;
    logic       sext;
    logic [1:0] offset;
    logic       kill;
  } lsu_tag_t;

  // Move the addressed lane down to bit 0, then zero/sign-extend to 32 bits.
  function automatic logic [31:0] lsu_format(
    input logic [31:0] rdata,
    input logic [1:0]  size,
    input logic        sext,
    input logic [1:0]  offset
  );
    logic [31:0] shifted;
    shifted = rdata >> {offset, 3'b000};
    case (size)
      LSU_BYTE: lsu_format = {{24{sext & shifted[7]}}, shifted[7:0]};
      LSU_HALF: lsu_format = {{16{sext & shifted[15]}}, shifted[15:0]};
      default:  lsu_format = shifted;
    endcase
  endfunction

endpackage

// File: rtl/frv_lsu_tagq.sv
// In-order circular queue of transaction tags with a broadcast kill.
module frv_lsu_tagq
  import frv_lsu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        push,
  input  lsu_tag_t    push_tag,
  input  logic        pop,
  input  logic        kill_all,
  output lsu_tag_t    head,
  output logic [PW:0] count,
  output logic        full,
  output logic        empty
);

  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  lsu_tag_t         mem [DEPTH];
  logic [DEPTH-1:0] kill_q;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Tag payload write; kill bits live in kill_q so a flush can hit every slot at once.
  // NOTE: the payload array has no reset -- an entry is only meaningful between its
  // push and pop, which the reset pointers and count already define.
  always_ff @(posedge g_clk) begin
    if (push_ok) mem[wptr] <= push_tag;
  end

  // Pointers, occupancy and per-slot kill flags.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; the later kill_q[wptr] write deliberately overrides kill_all.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      kill_q <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Marking free slots too is harmless: a push always rewrites its own flag.
      if (kill_all) kill_q <= '1;
      if (push_ok)  kill_q[wptr] <= push_tag.kill;
    end
  end

  // Oldest entry, with its live kill flag merged in.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned.
  always_comb begin
    head      = mem[rptr];
    head.kill = kill_q[rptr];
  end

endmodule

// File: rtl/frv_lsu_pipelined.sv
// Pipelined load/store unit: issues bus requests, tracks up to DEPTH
// outstanding transactions, formats load responses, supports flush and a
// leakage fence that drains the queue and scrubs the response register.
module frv_lsu_pipelined
  import frv_lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_busy,
  input  logic            req_load,
  input  logic            req_store,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            req_aerr,
  input  logic            hold_req,
  output logic            dmem_req,
  output logic            dmem_wen,
  output logic [3:0]      dmem_strb,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [XLEN-1:0] dmem_addr,
  input  logic            dmem_gnt,
  input  logic            dmem_recv,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_error,
  output logic            rsp_valid,
  output logic [4:0]      rsp_rd,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_error,
  input  logic            leak_fence,
  input  logic [XLEN-1:0] leak_prng,
  output logic            fence_done,
  output logic            spurious
);

  logic        misaligned;
  logic        issue_ok;
  logic        push;
  logic        pop;
  logic        q_full;
  logic        q_empty;
  logic [PW:0] q_count;
  logic        fence_pending;
  logic        fence_go;
  lsu_tag_t    push_tag;
  lsu_tag_t    head;

  // Request qualification: misaligned requests are consumed on the spot without a slot.
  assign misaligned = ((req_size == LSU_HALF) && req_addr[0]) ||
                      ((req_size == LSU_WORD) && (req_addr[1:0] != 2'b00));
  assign req_aerr   = req_valid && misaligned;
  // Full blocks issue even when a pop lands in the same cycle.
  assign issue_ok   = !hold_req && !q_full && !fence_pending && !flush;
  assign dmem_req   = req_valid && !misaligned && issue_ok;
  assign req_busy   = req_valid && !misaligned && !(dmem_req && dmem_gnt);
  assign push       = dmem_req && dmem_gnt;
  assign pop        = dmem_recv && !q_empty;

  // A fence completes once nothing is outstanding, nothing is arriving and nothing
  // is being accepted; a pulse on an empty, idle queue completes on the next edge.
  assign fence_go   = (fence_pending || leak_fence) && q_empty && !dmem_recv && !push;

  // Bus-side address and write data; the bus ignores the low address bits.
  assign dmem_addr  = {req_addr[XLEN-1:2], 2'b00};
  assign dmem_wen   = req_store;

  // Byte-lane strobe and lane-replicated write data.
  always_comb begin
    dmem_strb  = 4'b1111;
    dmem_wdata = req_wdata;
    case (req_size)
      LSU_BYTE: begin
        dmem_strb  = 4'b0001 << req_addr[1:0];
        dmem_wdata = {4{req_wdata[7:0]}};
      end
      LSU_HALF: begin
        dmem_strb  = 4'b0011 << req_addr[1:0];
        dmem_wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Tag captured at grant time.
  always_comb begin
    push_tag        = '0;
    push_tag.rd     = req_rd;
    push_tag.load   = req_load;
    push_tag.size   = req_size;
    push_tag.sext   = req_signed;
    push_tag.offset = req_addr[1:0];
    push_tag.kill   = 1'b0;
  end

  frv_lsu_tagq #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_tagq (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .push     (push),
    .push_tag (push_tag),
    .pop      (pop),
    .kill_all (flush),
    .head     (head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  // Registered response, fence sequencing and spurious-response detection.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      rsp_valid     <= 1'b0;
      rsp_error     <= 1'b0;
      rsp_rd        <= '0;
      rsp_data      <= '0;
      fence_done    <= 1'b0;
      fence_pending <= 1'b0;
      spurious      <= 1'b0;
    end else begin
      rsp_valid  <= 1'b0;
      fence_done <= 1'b0;
      if (pop) begin
        rsp_valid <= !head.kill && (head.load || dmem_error);
        rsp_error <= dmem_error;
        rsp_rd    <= head.rd;
        rsp_data  <= head.load ?
                     lsu_format(dmem_rdata, head.size, head.sext, head.offset) : '0;
      end
      if (dmem_recv && q_empty) spurious <= 1'b1;
      if (fence_go) begin
        fence_done    <= 1'b1;
        fence_pending <= 1'b0;
        rsp_data      <= leak_prng;
      end else begin
        fence_pending <= fence_pending || leak_fence;
      end
    end
  end

endmodule

// File: tb/tb_frv_lsu_pipelined.sv
// Self-checking bench for frv_lsu_pipelined: directed table of single
// transactions, hand-written multi-cycle sequences, then randomized traffic
// against a queue-based reference model.
module tb_frv_lsu_pipelined;
  import frv_lsu_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            g_clk = 1'b0;
  logic            g_resetn = 1'b0;
  logic            flush = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_busy;
  logic            req_load = 1'b0;
  logic            req_store = 1'b0;
  logic [1:0]      req_size = '0;
  logic            req_signed = 1'b0;
  logic [XLEN-1:0] req_addr = '0;
  logic [XLEN-1:0] req_wdata = '0;
  logic [4:0]      req_rd = '0;
  logic            req_aerr;
  logic            hold_req = 1'b0;
  logic            dmem_req;
  logic            dmem_wen;
  logic [3:0]      dmem_strb;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_addr;
  logic            dmem_gnt = 1'b0;
  logic            dmem_recv = 1'b0;
  logic [XLEN-1:0] dmem_rdata = '0;
  logic            dmem_error = 1'b0;
  logic            rsp_valid;
  logic [4:0]      rsp_rd;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_error;
  logic            leak_fence = 1'b0;
  logic [XLEN-1:0] leak_prng = '0;
  logic            fence_done;
  logic            spurious;

  always #5 g_clk = ~g_clk;

  frv_lsu_pipelined #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .g_clk (g_clk), .g_resetn (g_resetn), .flush (flush),
    .req_valid (req_valid), .req_busy (req_busy), .req_load (req_load),
    .req_store (req_store), .req_size (req_size), .req_signed (req_signed),
    .req_addr (req_addr), .req_wdata (req_wdata), .req_rd (req_rd),
    .req_aerr (req_aerr), .hold_req (hold_req), .dmem_req (dmem_req),
    .dmem_wen (dmem_wen), .dmem_strb (dmem_strb), .dmem_wdata (dmem_wdata),
    .dmem_addr (dmem_addr), .dmem_gnt (dmem_gnt), .dmem_recv (dmem_recv),
    .dmem_rdata (dmem_rdata), .dmem_error (dmem_error), .rsp_valid (rsp_valid),
    .rsp_rd (rsp_rd), .rsp_data (rsp_data), .rsp_error (rsp_error),
    .leak_fence (leak_fence), .leak_prng (leak_prng), .fence_done (fence_done),
    .spurious (spurious)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Move to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle();
    req_valid  = 1'b0; req_load = 1'b0; req_store = 1'b0; req_size = '0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
    hold_req   = 1'b0; dmem_gnt = 1'b0; dmem_recv = 1'b0; dmem_rdata = '0;
    dmem_error = 1'b0; flush = 1'b0; leak_fence = 1'b0;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [31:0] addr,
                            input logic [1:0] size, input logic sgn);
    req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0;
    req_size = size; req_signed = sgn; req_addr = addr; req_rd = rd;
  endtask

  // Directed single-transaction vectors.
  typedef struct {
    logic        store;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        exp_aerr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic        exp_rsp;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  // Reference model state.
  typedef struct {
    logic [4:0] rd;
    logic       load;
    logic [1:0] size;
    logic       sgn;
    logic [1:0] off;
    logic       killed;
  } mtag_t;

  mtag_t       mq[$];
  logic        m_fp, m_valid, m_done, m_spur, m_err;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input mtag_t t);
    logic [31:0]        v;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    v = rdata >> (8 * t.off);
    b = v[7:0];
    h = v[15:0];
    if (t.size == LSU_BYTE) return t.sgn ? 32'(b) : 32'(v[7:0]);
    if (t.size == LSU_HALF) return t.sgn ? 32'(h) : 32'(v[15:0]);
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        mis, ok, e_req, was_empty;
    logic [3:0]  e_strb;
    mtag_t       t;

    //                store size      sgn  addr          wdata         rdata         err  aerr strb     wdata         rsp  data
    vecs[0]  = '{1'b0, LSU_WORD, 1'b0, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0, 4'b1111, 32'h0,        1'b1, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, LSU_BYTE, 1'b1, 32'h0000_0203, 32'h0,        32'h8011_2233, 1'b0, 1'b0, 4'b1000, 32'h0,        1'b1, 32'hFFFF_FF80};
    vecs[2]  = '{1'b0, LSU_HALF, 1'b0, 32'h0000_0202, 32'h0,        32'h8011_2233, 1'b0, 1'b0, 4'b1100, 32'h0,        1'b1, 32'h0000_8011};
    vecs[3]  = '{1'b0, LSU_BYTE, 1'b0, 32'h0000_0201, 32'h0,        32'h8011_2233, 1'b0, 1'b0, 4'b0010, 32'h0,        1'b1, 32'h0000_0022};
    vecs[4]  = '{1'b0, LSU_HALF, 1'b1, 32'h0000_0200, 32'h0,        32'h1234_F00D, 1'b0, 1'b0, 4'b0011, 32'h0,        1'b1, 32'hFFFF_F00D};
    vecs[5]  = '{1'b0, LSU_BYTE, 1'b1, 32'h0000_0200, 32'h0,        32'h0000_007F, 1'b0, 1'b0, 4'b0001, 32'h0,        1'b1, 32'h0000_007F};
    vecs[6]  = '{1'b0, LSU_WORD, 1'b0, 32'h0000_0101, 32'h0,        32'h0,         1'b0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0};
    vecs[7]  = '{1'b0, LSU_HALF, 1'b0, 32'h0000_0103, 32'h0,        32'h0,         1'b0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0};
    vecs[8]  = '{1'b1, LSU_BYTE, 1'b0, 32'h0000_0102, 32'h0000_00AB, 32'h7777_7777, 1'b0, 1'b0, 4'b0100, 32'hABAB_ABAB, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, LSU_HALF, 1'b0, 32'h0000_0102, 32'h0000_1234, 32'h7777_7777, 1'b0, 1'b0, 4'b1100, 32'h1234_1234, 1'b0, 32'h0};
    vecs[10] = '{1'b1, LSU_WORD, 1'b0, 32'h0000_0108, 32'hCAFE_F00D, 32'h5555_5555, 1'b1, 1'b0, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h0};
    vecs[11] = '{1'b0, LSU_WORD, 1'b0, 32'h0000_010C, 32'h0,        32'h1122_3344, 1'b1, 1'b0, 4'b1111, 32'h0,        1'b1, 32'h1122_3344};

    // ---------------- reset state ----------------
    idle();
    g_resetn = 1'b0;
    repeat (3) tick();
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_error", rsp_error, 0);
    check("reset_rsp_rd", rsp_rd, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_fence_done", fence_done, 0);
    check("reset_spurious", spurious, 0);
    check("reset_req_busy", req_busy, 0);
    g_resetn = 1'b1;

    // ---------------- table-driven single transactions ----------------
    for (int i = 0; i < 12; i++) begin
      tick(); idle();
      req_valid = 1'b1; req_load = !vecs[i].store; req_store = vecs[i].store;
      req_size = vecs[i].size; req_signed = vecs[i].sgn; req_addr = vecs[i].addr;
      req_wdata = vecs[i].wdata; req_rd = 5'(i + 5); dmem_gnt = 1'b1;
      #1;
      check($sformatf("vec%0d_aerr", i), req_aerr, vecs[i].exp_aerr);
      check($sformatf("vec%0d_busy", i), req_busy, 0);
      check($sformatf("vec%0d_req", i), dmem_req, !vecs[i].exp_aerr);
      if (!vecs[i].exp_aerr) begin
        check($sformatf("vec%0d_strb", i), dmem_strb, vecs[i].exp_strb);
        check($sformatf("vec%0d_addr", i), dmem_addr, vecs[i].addr & 32'hFFFF_FFFC);
        check($sformatf("vec%0d_wdata", i), dmem_wdata, vecs[i].exp_wdata);
        check($sformatf("vec%0d_wen", i), dmem_wen, vecs[i].store);
      end
      tick(); idle();
      if (!vecs[i].exp_aerr) begin
        dmem_recv = 1'b1; dmem_rdata = vecs[i].rdata; dmem_error = vecs[i].err;
      end
      tick(); idle();
      check($sformatf("vec%0d_rsp_valid", i), rsp_valid, vecs[i].exp_rsp);
      if (vecs[i].exp_rsp) begin
        check($sformatf("vec%0d_rsp_rd", i), rsp_rd, 32'(i + 5));
        check($sformatf("vec%0d_rsp_data", i), rsp_data, vecs[i].exp_data);
        check($sformatf("vec%0d_rsp_error", i), rsp_error, vecs[i].err);
      end
    end

    // ---------------- full queue: 4 outstanding, 5th blocked ----------------
    for (int k = 0; k < 4; k++) begin
      tick(); idle();
      drive_load(5'(k + 1), 32'h300 + 32'(4 * k), LSU_WORD, 1'b0);
      dmem_gnt = 1'b1;
      #1;
      check("full_issue", dmem_req, 1);
    end
    tick(); idle();
    drive_load(5'd5, 32'h310, LSU_WORD, 1'b0);
    dmem_gnt = 1'b1;
    #1;
    check("full_req_blocked", dmem_req, 0);
    check("full_busy", req_busy, 1);
    tick();
    dmem_recv = 1'b1; dmem_rdata = 32'h1000_0001;
    #1;
    check("full_pop_cycle_blocked", dmem_req, 0);
    tick();
    dmem_recv = 1'b0;
    #1;
    check("full_rsp_valid", rsp_valid, 1);
    check("full_rsp_rd", rsp_rd, 1);
    check("full_rsp_data", rsp_data, 32'h1000_0001);
    check("full_5th_issues", dmem_req, 1);
    check("full_5th_busy", req_busy, 0);
    for (int k = 0; k < 4; k++) begin
      tick(); idle();
      dmem_recv = 1'b1; dmem_rdata = 32'h1000_0002 + 32'(k);
      tick(); idle();
      check("order_rsp_valid", rsp_valid, 1);
      check("order_rsp_rd", rsp_rd, 32'(k + 2));
      check("order_rsp_data", rsp_data, 32'h1000_0002 + 32'(k));
    end

    // ---------------- flush kills in-flight entries ----------------
    for (int k = 0; k < 2; k++) begin
      tick(); idle();
      drive_load(5'(k + 7), 32'h380 + 32'(4 * k), LSU_WORD, 1'b0);
      dmem_gnt = 1'b1;
    end
    tick(); idle();
    flush = 1'b1;
    drive_load(5'd9, 32'h390, LSU_WORD, 1'b0);
    dmem_gnt = 1'b1;
    #1;
    check("flush_blocks_issue", dmem_req, 0);
    for (int k = 0; k < 2; k++) begin
      tick(); idle();
      dmem_recv = 1'b1; dmem_rdata = 32'hBBBB_0000 + 32'(k);
      tick(); idle();
      check("flush_killed_rsp", rsp_valid, 0);
    end
    tick(); idle();
    drive_load(5'd10, 32'h400, LSU_WORD, 1'b0);
    dmem_gnt = 1'b1;
    tick(); idle();
    dmem_recv = 1'b1; dmem_rdata = 32'h0BAD_CAFE;
    tick(); idle();
    check("post_flush_valid", rsp_valid, 1);
    check("post_flush_rd", rsp_rd, 10);
    check("post_flush_data", rsp_data, 32'h0BAD_CAFE);

    // ---------------- leakage fence with 3 outstanding ----------------
    for (int k = 0; k < 3; k++) begin
      tick(); idle();
      drive_load(5'(k + 11), 32'h480 + 32'(4 * k), LSU_WORD, 1'b0);
      dmem_gnt = 1'b1;
    end
    tick(); idle();
    leak_fence = 1'b1; leak_prng = 32'hA5A5_A5A5;
    tick(); idle();
    drive_load(5'd14, 32'h500, LSU_WORD, 1'b0);
    dmem_gnt = 1'b1;
    #1;
    check("fence_blocks_issue", dmem_req, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      dmem_recv = 1'b1; dmem_rdata = 32'h2000_0000 + 32'(k);
      #1;
      check("fence_drain_blocked", dmem_req, 0);
      tick();
      dmem_recv = 1'b0;
      #1;
      check("fence_drain_rsp_valid", rsp_valid, 1);
      check("fence_drain_rsp_rd", rsp_rd, 32'(k + 11));
      check("fence_drain_rsp_data", rsp_data, 32'h2000_0000 + 32'(k));
      check("fence_drain_done_low", fence_done, 0);
      check("fence_still_blocked", dmem_req, 0);
    end
    tick();
    dmem_gnt = 1'b0;
    #1;
    check("fence_done_pulse", fence_done, 1);
    check("fence_rsp_valid_low", rsp_valid, 0);
    check("fence_scrub_data", rsp_data, 32'hA5A5_A5A5);
    check("fence_release_req", dmem_req, 1);
    check("fence_release_busy", req_busy, 1);
    tick(); idle();
    check("fence_done_single", fence_done, 0);
    leak_fence = 1'b1; leak_prng = 32'h5A5A_0F0F;
    tick(); idle();
    check("fence_empty_done", fence_done, 1);
    check("fence_empty_scrub", rsp_data, 32'h5A5A_0F0F);
    tick(); idle();
    check("fence_empty_done_low", fence_done, 0);

    // ---------------- spurious response ----------------
    check("spurious_before", spurious, 0);
    dmem_recv = 1'b1; dmem_rdata = 32'h3333_3333;
    tick(); idle();
    check("spurious_set", spurious, 1);
    check("spurious_no_rsp", rsp_valid, 0);
    tick(); idle();
    check("spurious_sticky", spurious, 1);

    // ---------------- reset mid-operation ----------------
    for (int k = 0; k < 2; k++) begin
      tick(); idle();
      drive_load(5'(k + 20), 32'h600 + 32'(4 * k), LSU_WORD, 1'b0);
      dmem_gnt = 1'b1;
    end
    tick(); idle();
    g_resetn = 1'b0;
    tick();
    g_resetn = 1'b1;
    check("midreset_spurious_clr", spurious, 0);
    dmem_recv = 1'b1; dmem_rdata = 32'h4444_4444;
    tick(); idle();
    check("midreset_spurious_set", spurious, 1);
    check("midreset_no_rsp", rsp_valid, 0);

    // ---------------- randomized traffic against the reference model ----------------
    tick(); idle();
    g_resetn = 1'b0;
    tick();
    g_resetn = 1'b1;
    mq.delete();
    m_fp = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_spur = 1'b0;
    m_err = 1'b0; m_rd = '0; m_data = '0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      check("rand_rsp_valid", rsp_valid, m_valid);
      if (m_valid) begin
        check("rand_rsp_rd", rsp_rd, m_rd);
        check("rand_rsp_data", rsp_data, m_data);
        check("rand_rsp_error", rsp_error, m_err);
      end
      check("rand_fence_done", fence_done, m_done);
      if (m_done) check("rand_fence_scrub", rsp_data, m_data);
      check("rand_spurious", spurious, m_spur);

      idle();
      req_valid  = ($urandom_range(0, 3) != 0);
      req_load   = 1'($urandom_range(0, 1));
      req_store  = !req_load;
      req_size   = 2'($urandom_range(0, 2));
      req_signed = 1'($urandom_range(0, 1));
      req_addr   = $urandom;
      req_wdata  = $urandom;
      req_rd     = 5'($urandom);
      hold_req   = ($urandom_range(0, 7) == 0);
      dmem_gnt   = 1'($urandom_range(0, 1));
      dmem_recv  = (mq.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
      dmem_rdata = $urandom;
      dmem_error = ($urandom_range(0, 15) == 0);
      flush      = ($urandom_range(0, 31) == 0);
      if (!req_valid && $urandom_range(0, 15) == 0) begin
        leak_fence = 1'b1;
        leak_prng  = $urandom;
      end
      #1;

      mis   = (req_size == LSU_HALF && req_addr[0]) ||
              (req_size == LSU_WORD && req_addr[1:0] != 2'b00);
      ok    = !hold_req && mq.size() < DEPTH && !m_fp && !flush;
      e_req = req_valid && !mis && ok;
      check("rand_aerr", req_aerr, req_valid && mis);
      check("rand_req", dmem_req, e_req);
      check("rand_busy", req_busy, req_valid && !mis && !(e_req && dmem_gnt));
      if (e_req) begin
        e_strb = 4'(((1 << (1 << req_size)) - 1) << req_addr[1:0]);
        check("rand_strb", dmem_strb, e_strb);
        check("rand_addr", dmem_addr, req_addr & 32'hFFFF_FFFC);
      end

      m_valid   = 1'b0;
      m_done    = 1'b0;
      was_empty = (mq.size() == 0);
      if (dmem_recv && was_empty) m_spur = 1'b1;
      if (dmem_recv && !was_empty) begin
        t       = mq.pop_front();
        m_valid = !t.killed && (t.load || dmem_error);
        m_rd    = t.rd;
        m_err   = dmem_error;
        m_data  = t.load ? ref_load(dmem_rdata, t) : 32'h0;
      end
      if (flush) foreach (mq[k]) mq[k].killed = 1'b1;
      if (e_req && dmem_gnt)
        mq.push_back('{rd: req_rd, load: req_load, size: req_size, sgn: req_signed,
                       off: req_addr[1:0], killed: 1'b0});
      if ((m_fp || leak_fence) && was_empty && !dmem_recv) begin
        m_done = 1'b1;
        m_data = leak_prng;
        m_fp   = 1'b0;
      end else if (leak_fence) begin
        m_fp = 1'b1;
      end
    end

    tick(); idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
